// File: rtl/triple_sender_pkg.sv
// Shared types and default sizing for triple_sender and its wait_timer helper.
package triple_sender_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH          = 8;
  localparam int unsigned DEF_NUM_WORDS      = 3;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  // Word index needs at least one bit even for single-word frames.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Loadable up/down cycle counter with synchronous clear and a limit-match flag.
module wait_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             up_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = up_i ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == limit_i);

endmodule

// File: rtl/triple_sender.sv
// Captures a NUM_WORDS frame, streams it on putFlag/value, then waits for accDone.
// Optional WAIT_ACK abort is enabled by defining TRIPLE_SENDER_TIMEOUT_EN.
module triple_sender
  import triple_sender_pkg::*;
#(
  parameter int unsigned WIDTH          = DEF_WIDTH,
  parameter int unsigned NUM_WORDS      = DEF_NUM_WORDS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_WORDS*WIDTH-1:0] words,
  input  logic                       accDone,
  output logic                       putFlag,
  output logic [WIDTH-1:0]           value,
  output logic                       busy,
  output logic                       sent,
  output logic                       err
);

  localparam int unsigned      IDX_W    = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [NUM_WORDS-1:0][WIDTH-1:0]    frame_q, frame_d;
  logic                               sent_q, sent_d;
  logic                               err_q, err_d;
  logic                               timeout;

`ifdef TRIPLE_SENDER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic tmr_clr, tmr_en, tmr_expired;

  // Counter is zeroed on the edge entering WAIT_ACK; the TIMEOUT_CYCLES-th
  // WAIT_ACK edge sees it at TIMEOUT_CYCLES-1 and aborts.
  assign tmr_clr = (state_q == SEND) && (idx_q == IDX_LAST);
  assign tmr_en  = (state_q == WAIT_ACK);

  wait_timer #(.CNT_W(TMO_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (tmr_clr),
    .load_i     (1'b0),
    .load_val_i ({TMO_W{1'b0}}),
    .up_i       (1'b1),
    .en_i       (tmr_en),
    .limit_i    (TMO_W'(TIMEOUT_CYCLES - 1)),
    .expired_o  (tmr_expired)
  );

  assign timeout = tmr_expired;
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    sent_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          frame_d = words;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // idx parks on the last word so value keeps showing it afterwards.
        if (idx_q == IDX_LAST) state_d = WAIT_ACK;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      WAIT_ACK: begin
        if (accDone) begin
          sent_d  = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      sent_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
    end
  end

  assign putFlag = (state_q == SEND);
  assign value   = frame_q[idx_q];
  assign busy    = (state_q != IDLE);
  assign sent    = sent_q;
  assign err     = err_q;

endmodule

// File: tb/tb_triple_sender.sv
// Directed bench for triple_sender: main 3x8 instance plus 1-word and 4x16 instances.
module tb_triple_sender;

  logic        clk = 1'b0;
  logic        reset, accDone;
  logic        start, start1, start4;
  logic [23:0] words;
  logic [7:0]  words1;
  logic [63:0] words4;

  logic        putFlag, busy, sent, err;
  logic [7:0]  value;
  logic        putFlag1, busy1, sent1, err1;
  logic [7:0]  value1;
  logic        putFlag4, busy4, sent4, err4;
  logic [15:0] value4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  triple_sender #(.WIDTH(8), .NUM_WORDS(3), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .words(words), .accDone(accDone),
    .putFlag(putFlag), .value(value), .busy(busy), .sent(sent), .err(err));

  triple_sender #(.WIDTH(8), .NUM_WORDS(1), .TIMEOUT_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .words(words1), .accDone(accDone),
    .putFlag(putFlag1), .value(value1), .busy(busy1), .sent(sent1), .err(err1));

  triple_sender #(.WIDTH(16), .NUM_WORDS(4), .TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .words(words4), .accDone(accDone),
    .putFlag(putFlag4), .value(value4), .busy(busy4), .sent(sent4), .err(err4));

  // Advance one edge and land 1ns after it, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total_cnt++; if (putFlag !== 1'b0) $display("FAIL rst_putFlag: got %b want 0", putFlag); else pass_cnt++;
    total_cnt++; if (value !== 8'h00) $display("FAIL rst_value: got %h want 00", value); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (sent !== 1'b0) $display("FAIL rst_sent: got %b want 0", sent); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else pass_cnt++;
    total_cnt++; if ({putFlag1, busy1, putFlag4, busy4, value4} !== 20'h0)
      $display("FAIL rst_sweep: got %h want 00000", {putFlag1, busy1, putFlag4, busy4, value4}); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    words = {8'd30, 8'd20, 8'd10};
    start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++; if ({putFlag, busy, value} !== {2'b11, 8'd10}) $display("FAIL basic_w0: got %b%b/%0d want 11/10", putFlag, busy, value); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag, value} !== {1'b1, 8'd20}) $display("FAIL basic_w1: got %b/%0d want 1/20", putFlag, value); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag, value} !== {1'b1, 8'd30}) $display("FAIL basic_w2: got %b/%0d want 1/30", putFlag, value); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag, busy, sent, value} !== {3'b010, 8'd30}) $display("FAIL basic_wait: got %b%b%b/%0d want 010/30", putFlag, busy, sent, value); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag, busy, sent} !== 3'b010) $display("FAIL basic_wait2: got %b%b%b want 010", putFlag, busy, sent); else pass_cnt++;
    accDone = 1'b1;
    tick();
    accDone = 1'b0;
    total_cnt++; if ({sent, busy, putFlag} !== 3'b100) $display("FAIL basic_sent: got %b%b%b want 100", sent, busy, putFlag); else pass_cnt++;
    tick();
    total_cnt++; if ({sent, busy, err} !== 3'b000) $display("FAIL basic_after: got %b%b%b want 000", sent, busy, err); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    words = {8'd3, 8'd2, 8'd1};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    accDone = 1'b1;
    tick();
    accDone = 1'b0;
    total_cnt++; if ({sent, busy} !== 2'b10) $display("FAIL b2b_sent: got %b%b want 10", sent, busy); else pass_cnt++;
    words = {8'd6, 8'd5, 8'd4};
    start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++; if ({putFlag, busy, sent, value} !== {3'b110, 8'd4}) $display("FAIL b2b_w0: got %b%b%b/%0d want 110/4", putFlag, busy, sent, value); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag, value} !== {1'b1, 8'd5}) $display("FAIL b2b_w1: got %b/%0d want 1/5", putFlag, value); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag, value} !== {1'b1, 8'd6}) $display("FAIL b2b_w2: got %b/%0d want 1/6", putFlag, value); else pass_cnt++;
    tick();
    accDone = 1'b1;
    tick();
    accDone = 1'b0;
    total_cnt++; if ({sent, busy} !== 2'b10) $display("FAIL b2b_sent2: got %b%b want 10", sent, busy); else pass_cnt++;
    tick();
  endtask

  task automatic test_ignored();
    words = {8'h33, 8'h22, 8'h11};
    start = 1'b1;
    tick();
    total_cnt++; if ({putFlag, value} !== {1'b1, 8'h11}) $display("FAIL ign_w0: got %b/%h want 1/11", putFlag, value); else pass_cnt++;
    accDone = 1'b1;
    words   = 24'hFFFFFF;
    tick();
    total_cnt++; if ({putFlag, sent, value} !== {2'b10, 8'h22}) $display("FAIL ign_w1: got %b%b/%h want 10/22", putFlag, sent, value); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag, sent, value} !== {2'b10, 8'h33}) $display("FAIL ign_w2: got %b%b/%h want 10/33", putFlag, sent, value); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag, busy, sent, value} !== {3'b010, 8'h33}) $display("FAIL ign_wait: got %b%b%b/%h want 010/33", putFlag, busy, sent, value); else pass_cnt++;
    start = 1'b0;
    tick();
    accDone = 1'b0;
    total_cnt++; if ({sent, busy} !== 2'b10) $display("FAIL ign_sent: got %b%b want 10", sent, busy); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag, busy, sent} !== 3'b000) $display("FAIL ign_no_requeue: got %b%b%b want 000", putFlag, busy, sent); else pass_cnt++;
  endtask

  task automatic test_reset_mid_send();
    words = {8'd30, 8'd20, 8'd10};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total_cnt++; if ({putFlag, value} !== {1'b1, 8'd20}) $display("FAIL rmid_w1: got %b/%0d want 1/20", putFlag, value); else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++; if ({putFlag, busy, sent, err, value} !== 12'h000) $display("FAIL rmid_outs: got %b%b%b%b/%0d want 0000/0", putFlag, busy, sent, err, value); else pass_cnt++;
    accDone = 1'b1;
    tick();
    accDone = 1'b0;
    total_cnt++; if ({putFlag, busy, sent} !== 3'b000) $display("FAIL rmid_no_sent: got %b%b%b want 000", putFlag, busy, sent); else pass_cnt++;
  endtask

  task automatic test_timeout();
    words = {8'd9, 8'd8, 8'd7};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
`ifdef TRIPLE_SENDER_TIMEOUT_EN
    tick(); tick(); tick();
    total_cnt++; if ({busy, err} !== 2'b10) $display("FAIL tmo_pre: got %b%b want 10", busy, err); else pass_cnt++;
    tick();
    total_cnt++; if ({err, busy, sent} !== 3'b100) $display("FAIL tmo_err: got %b%b%b want 100", err, busy, sent); else pass_cnt++;
    tick();
    total_cnt++; if ({err, busy} !== 2'b00) $display("FAIL tmo_err_clr: got %b%b want 00", err, busy); else pass_cnt++;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    tick(); tick(); tick();
    accDone = 1'b1;
    tick();
    accDone = 1'b0;
    total_cnt++; if ({sent, err, busy} !== 3'b100) $display("FAIL tmo_ack_wins: got %b%b%b want 100", sent, err, busy); else pass_cnt++;
`else
    for (int i = 0; i < 20; i++) tick();
    total_cnt++; if ({busy, err, sent} !== 3'b100) $display("FAIL notmo_wait: got %b%b%b want 100", busy, err, sent); else pass_cnt++;
    accDone = 1'b1;
    tick();
    accDone = 1'b0;
    total_cnt++; if ({sent, err, busy} !== 3'b100) $display("FAIL notmo_sent: got %b%b%b want 100", sent, err, busy); else pass_cnt++;
`endif
    tick();
  endtask

  task automatic test_params();
    words1 = 8'hA5;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    total_cnt++; if ({putFlag1, busy1, value1} !== {2'b11, 8'hA5}) $display("FAIL nw1_w0: got %b%b/%h want 11/a5", putFlag1, busy1, value1); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag1, busy1} !== 2'b01) $display("FAIL nw1_wait: got %b%b want 01", putFlag1, busy1); else pass_cnt++;
    accDone = 1'b1;
    tick();
    accDone = 1'b0;
    total_cnt++; if ({sent1, busy1} !== 2'b10) $display("FAIL nw1_sent: got %b%b want 10", sent1, busy1); else pass_cnt++;

    words4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    total_cnt++; if ({putFlag4, value4} !== {1'b1, 16'h1111}) $display("FAIL nw4_w0: got %b/%h want 1/1111", putFlag4, value4); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag4, value4} !== {1'b1, 16'h2222}) $display("FAIL nw4_w1: got %b/%h want 1/2222", putFlag4, value4); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag4, value4} !== {1'b1, 16'h3333}) $display("FAIL nw4_w2: got %b/%h want 1/3333", putFlag4, value4); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag4, value4} !== {1'b1, 16'h4444}) $display("FAIL nw4_w3: got %b/%h want 1/4444", putFlag4, value4); else pass_cnt++;
    tick();
    total_cnt++; if ({putFlag4, busy4} !== 2'b01) $display("FAIL nw4_wait: got %b%b want 01", putFlag4, busy4); else pass_cnt++;
    accDone = 1'b1;
    tick();
    accDone = 1'b0;
    total_cnt++; if ({sent4, busy4, err4, err1} !== 4'b1000) $display("FAIL nw4_sent: got %b%b%b%b want 1000", sent4, busy4, err4, err1); else pass_cnt++;
  endtask

  initial begin
    reset   = 1'b1;
    accDone = 1'b0;
    start   = 1'b0;
    start1  = 1'b0;
    start4  = 1'b0;
    words   = '0;
    words1  = '0;
    words4  = '0;
    #2;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignored();
    test_reset_mid_send();
    test_timeout();
    test_params();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
